// File: rtl/qsfp_i2c_slave.sv
`timescale 1ns/1ps
// qsfp_i2c_slave
// I2C target that emulates the QSFP management interface: a 256-byte register
// map addressed through an 8-bit auto-incrementing pointer. A host-side port
// preloads and inspects the map. SCL is never driven and the clock is never
// stretched.
// Optional build macro QSFP_I2C_SLAVE_WP_EN: I2C writes below WP_BOUNDARY are
// ACKed and advance the pointer but leave the map untouched and raise no strobe.
module qsfp_i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h50,
   parameter int         FILTER      = 3,
   parameter logic [7:0] WP_BOUNDARY = 8'h80
) (
   input  logic       wb_clk_i,
   input  logic       wb_rstn_i,
   input  logic       scl_pad_i,
   input  logic       sda_pad_i,
   output logic       sda_pad_o,
   output logic       sda_padoen_o,
   input  logic [7:0] host_adr_i,
   input  logic [7:0] host_dat_i,
   input  logic       host_we_i,
   output logic [7:0] host_dat_o,
   output logic       busy_o,
   output logic       wr_strobe_o,
   output logic [7:0] wr_adr_o
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
   } state_t;

   localparam logic [3:0] FLT_LAST = 4'(FILTER - 1);

`ifdef QSFP_I2C_SLAVE_WP_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   // Bit 1 carries SCL, bit 0 carries SDA through the input path.
   logic [1:0] raw, sync_a, sync_b, filt, filt_q;
   logic [3:0] flt_cnt [2];

   logic scl, sda, scl_rise, scl_fall, start_cond, stop_cond;

   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shreg_q, shreg_d;
   logic [7:0] ptr_q, ptr_d;
   logic       first_q, first_d;
   logic       busy_q, busy_d;
   logic       oen_q, oen_d;
   logic       strobe_q, strobe_d;
   logic [7:0] wr_adr_q, wr_adr_d;
   logic       i2c_we;
   logic       wr_ok;
   logic [7:0] byte_in;
   logic [7:0] rd_byte;

   logic [7:0] mem [256];

   assign raw = {scl_pad_i, sda_pad_i};

   // Two-flop synchronizer into the wb_clk_i domain; an idle bus reads as 1.
   // NOTE: clocked state is always assigned with <= so every flop samples the
   // pre-edge value of its neighbours, exactly like the hardware.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         sync_a <= '1;
         sync_b <= '1;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Stability filter: a new level is accepted after FILTER consecutive cycles.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         filt       <= '1;
         filt_q     <= '1;
         flt_cnt[0] <= '0;
         flt_cnt[1] <= '0;
      end else begin
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] == filt[i]) begin
               flt_cnt[i] <= '0;
            end else if (flt_cnt[i] == FLT_LAST) begin
               filt[i]    <= sync_b[i];
               flt_cnt[i] <= '0;
            end else begin
               flt_cnt[i] <= flt_cnt[i] + 4'd1;
            end
         end
      end
   end

   assign scl        = filt[1];
   assign sda        = filt[0];
   assign scl_rise   =  scl & ~filt_q[1];
   assign scl_fall   = ~scl &  filt_q[1];
   assign start_cond =  scl &  filt_q[1] &  filt_q[0] & ~sda;
   assign stop_cond  =  scl &  filt_q[1] & ~filt_q[0] &  sda;

   assign byte_in = {shreg_q[6:0], sda};
   assign rd_byte = mem[ptr_q];
   assign wr_ok   = !WP_ON || (ptr_q >= WP_BOUNDARY);

   // Protocol state and datapath registers.
   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         shreg_q    <= '0;
         ptr_q      <= '0;
         first_q    <= 1'b0;
         busy_q     <= 1'b0;
         oen_q      <= 1'b1;
         strobe_q   <= 1'b0;
         wr_adr_q   <= '0;
         host_dat_o <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         ptr_q      <= ptr_d;
         first_q    <= first_d;
         busy_q     <= busy_d;
         oen_q      <= oen_d;
         strobe_q   <= strobe_d;
         wr_adr_q   <= wr_adr_d;
         host_dat_o <= mem[host_adr_i];
      end
   end

   // Next-state and datapath decode from filtered bus events.
   // NOTE: every signal gets its hold/default value first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      ptr_d     = ptr_q;
      first_d   = first_q;
      busy_d    = busy_q;
      oen_d     = oen_q;
      strobe_d  = 1'b0;
      wr_adr_d  = wr_adr_q;
      i2c_we    = 1'b0;

      if (stop_cond) begin
         state_d   = IDLE;
         oen_d     = 1'b1;
         busy_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (start_cond) begin
         state_d   = ADDR;
         oen_d     = 1'b1;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            ADDR: begin
               if (scl_rise) begin
                  shreg_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  if (shreg_q[7:1] == SLAVE_ADDR) begin
                     state_d = ADDR_ACK;
                     oen_d   = 1'b0;
                     busy_d  = 1'b1;
                  end else begin
                     state_d = IGNORE;
                     busy_d  = 1'b0;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = '0;
                  if (shreg_q[0]) begin
                     state_d = RD_BYTE;
                     shreg_d = rd_byte;
                     oen_d   = rd_byte[7];
                  end else begin
                     state_d = WR_BYTE;
                     oen_d   = 1'b1;
                     first_d = 1'b1;
                  end
               end
            end
            WR_BYTE: begin
               if (scl_rise) begin
                  shreg_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (first_q) begin
                        ptr_d   = byte_in;
                        first_d = 1'b0;
                     end else begin
                        ptr_d = ptr_q + 8'd1;
                        if (wr_ok) begin
                           i2c_we   = 1'b1;
                           strobe_d = 1'b1;
                           wr_adr_d = ptr_q;
                        end
                     end
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  state_d = WR_ACK;
                  oen_d   = 1'b0;
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  state_d   = WR_BYTE;
                  oen_d     = 1'b1;
                  bit_cnt_d = '0;
               end
            end
            RD_BYTE: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     state_d   = RD_ACK;
                     oen_d     = 1'b1;
                     ptr_d     = ptr_q + 8'd1;
                     bit_cnt_d = '0;
                  end else begin
                     shreg_d = {shreg_q[6:0], 1'b0};
                     oen_d   = shreg_q[6];
                  end
               end
            end
            RD_ACK: begin
               // bit_cnt marks that the master ACKed on this ninth clock.
               if (scl_rise) begin
                  if (sda) begin
                     state_d = IGNORE;
                     busy_d  = 1'b0;
                  end else begin
                     bit_cnt_d = 4'd1;
                  end
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  state_d   = RD_BYTE;
                  bit_cnt_d = '0;
                  shreg_d   = rd_byte;
                  oen_d     = rd_byte[7];
               end
            end
            default: ;
         endcase
      end
   end

   // Register map write port; a host write to the same address takes priority.
   // NOTE: the map is deliberately left out of reset so it stays a plain
   // memory array and survives a reset pulse.
   always_ff @(posedge wb_clk_i) begin
      if (i2c_we && !(host_we_i && host_adr_i == ptr_q)) begin
         mem[ptr_q] <= byte_in;
      end
      if (host_we_i) begin
         mem[host_adr_i] <= host_dat_i;
      end
   end

   assign sda_pad_o    = 1'b0;
   assign sda_padoen_o = oen_q;
   assign busy_o       = busy_q;
   assign wr_strobe_o  = strobe_q;
   assign wr_adr_o     = wr_adr_q;

endmodule

// File: tb/tb_qsfp_i2c_slave.sv
`timescale 1ns/1ps
// Testbench for qsfp_i2c_slave: a bit-banged I2C master drives the responder
// while a transaction-level model tracks the register map, pointer and busy
// flag; a compare process checks every write strobe against the model.
module tb_qsfp_i2c_slave;

   localparam int         Q     = 200;     // quarter bit period in ns
   localparam logic [6:0] SLAVE = 7'h50;
`ifdef QSFP_I2C_SLAVE_WP_EN
   localparam bit WP_ON_TB = 1'b1;
`else
   localparam bit WP_ON_TB = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_bus;
   logic       sda_pad_o, sda_padoen_o;
   logic [7:0] host_adr = '0;
   logic [7:0] host_dat = '0;
   logic       host_we = 1'b0;
   logic [7:0] host_dat_o;
   logic       busy_o, wr_strobe_o;
   logic [7:0] wr_adr_o;

   int errors = 0;
   int checks = 0;

   // Model state.
   logic [7:0] m_mem [256];
   logic [7:0] m_ptr = '0;
   bit         m_addressed = 1'b0;
   bit         m_rw = 1'b0;
   bit         m_first = 1'b0;
   bit         m_busy = 1'b0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   // Open-drain SDA: either side can pull the line low.
   assign sda_bus = sda_padoen_o ? sda_m : (sda_m & sda_pad_o);

   qsfp_i2c_slave dut (
      .wb_clk_i     (clk),
      .wb_rstn_i    (rst_n),
      .scl_pad_i    (scl_m),
      .sda_pad_i    (sda_bus),
      .sda_pad_o    (sda_pad_o),
      .sda_padoen_o (sda_padoen_o),
      .host_adr_i   (host_adr),
      .host_dat_i   (host_dat),
      .host_we_i    (host_we),
      .host_dat_o   (host_dat_o),
      .busy_o       (busy_o),
      .wr_strobe_o  (wr_strobe_o),
      .wr_adr_o     (wr_adr_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit i2c_writable(input logic [7:0] a);
      return !WP_ON_TB || (a >= 8'h80);
   endfunction

   // Every committed I2C write must match the next address the model expects.
   always @(negedge clk) begin
      if (rst_n && wr_strobe_o) begin
         if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_wr_strobe got=%0h expected=none at %0t", wr_adr_o, $time);
         end else begin
            check("wr_adr_o", wr_adr_o, exp_q.pop_front());
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- bus-level master ----------------
   task automatic i2c_start;
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b0; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic i2c_stop;
      sda_m = 1'b0; #Q;
      scl_m = 1'b1; #Q;
      sda_m = 1'b1; #Q;
   endtask

   // Send the n most significant bits of b; g selects a bit after whose
   // falling edge a one-cycle SCL glitch is injected (-1 for none).
   task automatic tx_bits(input logic [7:0] b, input int n, input int g);
      for (int i = 7; i > 7 - n; i--) begin
         sda_m = b[i]; #Q;
         scl_m = 1'b1; #(2*Q);
         scl_m = 1'b0; #(Q/2);
         if (i == g) begin
            @(negedge clk) scl_m = 1'b1;
            @(negedge clk) scl_m = 1'b0;
         end
         #(Q/2);
      end
   endtask

   task automatic tx_byte(input logic [7:0] b, input int g, output logic ack);
      tx_bits(b, 8, g);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      ack = sda_bus; #Q;
      scl_m = 1'b0; #Q;
   endtask

   task automatic rx_byte(input logic nack, output logic [7:0] d);
      sda_m = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         #Q; scl_m = 1'b1;
         #Q; d[i] = sda_bus;
         #Q; scl_m = 1'b0;
         #Q;
      end
      sda_m = nack; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
      sda_m = 1'b1;
   endtask

   // ---------------- model-level transactions ----------------
   task automatic m_start;
      i2c_start();
      m_addressed = 1'b0;
   endtask

   task automatic m_stop;
      i2c_stop();
      m_addressed = 1'b0;
      m_busy = 1'b0;
      check("busy_after_stop", busy_o, m_busy);
   endtask

   task automatic m_addr(input logic [7:0] b, input int g = -1);
      logic ack;
      bit   hit;
      hit = (b[7:1] == SLAVE);
      tx_byte(b, g, ack);
      check("addr_ack", ack, hit ? 1'b0 : 1'b1);
      m_addressed = hit;
      m_rw = b[0];
      m_first = 1'b1;
      m_busy = hit;
      check("busy_after_addr", busy_o, m_busy);
   endtask

   task automatic m_wbyte(input logic [7:0] b, input int g = -1);
      logic ack;
      bit   take;
      take = m_addressed && !m_rw;
      if (take) begin
         if (m_first) begin
            m_ptr = b;
            m_first = 1'b0;
         end else begin
            if (i2c_writable(m_ptr)) begin
               m_mem[m_ptr] = b;
               exp_q.push_back(m_ptr);
            end
            m_ptr = m_ptr + 8'd1;
         end
      end
      tx_byte(b, g, ack);
      check("data_ack", ack, take ? 1'b0 : 1'b1);
   endtask

   task automatic m_rbyte(input logic nack, output logic [7:0] d);
      rx_byte(nack, d);
      check("rd_data", d, m_mem[m_ptr]);
      m_ptr = m_ptr + 8'd1;
      if (nack) begin
         m_busy = 1'b0;
         m_addressed = 1'b0;
      end
      check("busy_after_read", busy_o, m_busy);
   endtask

   task automatic host_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      host_adr = a;
      host_dat = d;
      host_we = 1'b1;
      @(negedge clk);
      host_we = 1'b0;
      m_mem[a] = d;
   endtask

   // Registered host read compared with both the model and a literal.
   task automatic host_check(input string name, input logic [7:0] a, input logic [7:0] lit);
      @(negedge clk);
      host_adr = a;
      @(negedge clk);
      check(name, host_dat_o, m_mem[a]);
      check({name, "_lit"}, host_dat_o, lit);
   endtask

   initial begin
      logic [7:0] d;

      // Reset state.
      #22;
      check("rst_padoen", sda_padoen_o, 1'b1);
      check("rst_pad_o", sda_pad_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_strobe", wr_strobe_o, 1'b0);
      check("rst_wr_adr", wr_adr_o, 8'h00);
      check("rst_host_dat", host_dat_o, 8'h00);
      @(negedge clk) rst_n = 1'b1;
      #Q;

      // 1: host preload, pointer set by write, repeated START, read, NACK.
      host_write(8'h10, 8'hA5);
      host_check("t1_host", 8'h10, 8'hA5);
      m_start(); m_addr(8'hA0); m_wbyte(8'h10);
      m_start(); m_addr(8'hA1); m_rbyte(1'b1, d);
      check("t1_read_lit", d, 8'hA5);
      m_stop();

      // 2: burst write wrapping the pointer FF -> 00.
      m_start(); m_addr(8'hA0);
      m_wbyte(8'hFE); m_wbyte(8'h11); m_wbyte(8'h22); m_wbyte(8'h33);
      m_stop();
      host_check("t2_fe", 8'hFE, 8'h11);
      host_check("t2_ff", 8'hFF, 8'h22);
      host_check("t2_00", 8'h00, 8'h33);

      // 3: address mismatch, following byte is ignored.
      m_start(); m_addr(8'hA2); m_wbyte(8'h77);
      m_stop();

      // 4: STOP after 4 data bits discards the byte and keeps the pointer.
      host_write(8'h31, 8'hC3);
      m_start(); m_addr(8'hA0); m_wbyte(8'h30); m_wbyte(8'h44);
      tx_bits(8'hBB, 4, -1);
      m_stop();
      m_start(); m_addr(8'hA1); m_rbyte(1'b1, d);
      check("t4_ptr_kept_lit", d, 8'hC3);
      m_stop();
      host_check("t4_30", 8'h30, 8'h44);

      // 5a: one-cycle SCL glitches in the address and data phases.
      m_start(); m_addr(8'hA0, 4); m_wbyte(8'h50, 2); m_wbyte(8'h6E, 5);
      m_stop();
      host_check("t5_glitch", 8'h50, 8'h6E);

      // 5b: reset while the responder drives the read address ACK.
      m_start();
      tx_bits(8'hA1, 8, -1);
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      check("t5_ack_driven", sda_padoen_o, 1'b0);
      check("t5_busy_before_rst", busy_o, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_release", sda_padoen_o, 1'b1);
      check("t5_rst_busy", busy_o, 1'b0);
      #Q; scl_m = 1'b0; #Q;
      @(negedge clk) rst_n = 1'b1;
      m_ptr = 8'h00; m_busy = 1'b0; m_addressed = 1'b0;
      #Q;
      m_stop();
      // Pointer restarts at 0 while the map keeps its contents.
      m_start(); m_addr(8'hA1); m_rbyte(1'b1, d);
      check("t5_after_rst_lit", d, 8'h33);
      m_stop();

      // 6: write-protect boundary (all writable in the default build).
      host_write(8'h20, 8'h01);
      m_start(); m_addr(8'hA0); m_wbyte(8'h20); m_wbyte(8'h55); m_stop();
      m_start(); m_addr(8'hA0); m_wbyte(8'h90); m_wbyte(8'h55); m_stop();
      host_check("t6_20", 8'h20, WP_ON_TB ? 8'h01 : 8'h55);
      host_check("t6_90", 8'h90, 8'h55);

      // 7: host and I2C write the same address together; the host value stays.
      m_start(); m_addr(8'hA0); m_wbyte(8'h40);
      @(negedge clk);
      host_adr = 8'h40; host_dat = 8'h99; host_we = 1'b1;
      m_wbyte(8'h66);
      @(negedge clk) host_we = 1'b0;
      m_mem[8'h40] = 8'h99;
      m_stop();
      host_check("t7_collision", 8'h40, 8'h99);

      #Q;
      check("strobe_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/qsfp_i2c_slave.md
Name: qsfp_i2c_slave

Overview:
I2C responder that emulates the QSFP module management interface: a 256-byte register map with an 8-bit address pointer. It is the target-side counterpart of the SoC's I2C master controllers. It is used in simulation and loopback builds to exercise the I2C master path without real optics. A host-side port lets the system preload and inspect the register map.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit I2C address matched by this responder.
FILTER, 3, number of consecutive wb_clk_i cycles a synchronized SCL/SDA level must hold before it is accepted (range 1..15).
WP_BOUNDARY, 8'h80, first writable register address when write protect is compiled in.

Ports:
wb_clk_i  in  1  system clock
wb_rstn_i  in  1  asynchronous active-low reset
scl_pad_i  in  1  SCL line as seen at the pad
sda_pad_i  in  1  SDA line as seen at the pad
sda_pad_o  out  1  SDA output value, constant 0 (open drain)
sda_padoen_o  out  1  SDA output enable, active-low: 0 pulls SDA low, 1 releases it
host_adr_i  in  8  host register address
host_dat_i  in  8  host write data
host_we_i  in  1  host write strobe, one byte per cycle
host_dat_o  out  8  mem[host_adr_i], registered, 1-cycle latency
busy_o  out  1  high from an address match until STOP, address mismatch, or master NACK
wr_strobe_o  out  1  one-cycle pulse when an I2C write commits a byte
wr_adr_o  out  8  register address of the committed byte, valid with wr_strobe_o

Behaviour:
- Reset values: sda_padoen_o=1, sda_pad_o=0, busy_o=0, wr_strobe_o=0, wr_adr_o=0, host_dat_o=0, pointer=0, state IDLE. The register map is not reset.
- Input path: 2-flop synchronizer, then a FILTER-cycle stability filter. Filtered levels reset to 1. All decoding uses the filtered scl/sda and their edges.
- START: sda 1->0 while scl=1. STOP: sda 0->1 while scl=1. Both are recognized in every state, including mid-byte. START and repeated START go to ADDR. STOP goes to IDLE and releases SDA.
- Data is sampled on filtered SCL rising. SDA is changed only on filtered SCL falling.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- ADDR: shift in 8 bits, MSB first.
  - If [7:1]==SLAVE_ADDR: drive ACK (sda_padoen_o=0) from the 8th SCL falling edge to the 9th, set busy_o, then go to WR_BYTE (R/W=0) or RD_BYTE (R/W=1).
  - On mismatch: go to IGNORE with no ACK. IGNORE exits only on START or STOP.
- WR_BYTE/WR_ACK:
  - The first byte after the address loads the pointer.
  - Each later byte writes mem[pointer], pulses wr_strobe_o with wr_adr_o=pointer on the 8th SCL rising edge, then pointer++.
  - Every byte is ACKed.
- RD_BYTE: load mem[pointer] at the address-ACK release (or the previous ACK SCL falling edge) and shift it out MSB first. A 1 bit releases SDA; a 0 bit pulls it low. pointer++ after the 8th bit.
- RD_ACK: SDA is released and the master's bit is sampled on the 9th SCL rising edge.
  - ACK (0): next byte.
  - NACK (1): clear busy_o, go to IGNORE.
- Pointer is 8 bits and wraps 8'hFF -> 8'h00 on both reads and writes.
- A transfer aborted mid-byte by START/STOP discards the partial byte. No write commits and the pointer is unchanged.
- Collision: host write and I2C write to the same address in the same cycle — the host wins. The I2C write still pulses wr_strobe_o.
- Asserting reset mid-transfer releases SDA immediately (asynchronous).
- No clock stretching. SCL is never driven.

Optional Feature:
QSFP_I2C_SLAVE_WP_EN:
- Defined: I2C writes to addresses below WP_BOUNDARY are ACKed and the pointer increments, but mem is unchanged and wr_strobe_o does not pulse. Host writes are unaffected.
- Undefined: all 256 bytes are writable over I2C.

Test Plan:
1. Host writes mem[8'h10]=8'hA5. I2C sequence START, 8'hA0, 8'h10, repeated START, 8'hA1, read 1 byte, NACK, STOP -> responder ACKs all three writes, returns 8'hA5, busy_o falls after the NACK.
2. I2C writes 8'hA0, 8'hFE, then 8'h11, 8'h22, 8'h33 -> mem[FE]=11, mem[FF]=22, mem[00]=33; three wr_strobe_o pulses with wr_adr_o FE, FF, 00.
3. Address 8'hA2 (mismatch) -> SDA stays released on the 9th clock, state is IGNORE, no mem change, busy_o stays 0.
4. STOP issued after 4 data bits of a write byte -> no commit, pointer unchanged; the next transaction behaves normally.
5. 1-cycle glitch on SCL with FILTER=3 -> no bit shifted and no state change. wb_rstn_i pulsed during a read ACK -> sda_padoen_o=1 immediately.
6. With QSFP_I2C_SLAVE_WP_EN defined, I2C write of 8'h55 to 8'h20 -> ACKed, mem[20] unchanged, no wr_strobe_o. The same write to 8'h90 -> committed.
